// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default line settings,
// used by both the RX and TX sides.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_t;

  localparam int         UART_CLKS_PER_BIT = 434;
  localparam logic [7:0] UART_LAST_CHAR    = 8'h0A;

endpackage

// File: rtl/uart_rx_core.sv
// UART receive core: input synchronizer, bit-timing FSM and shift register.
// Emits a one-cycle o_done with the byte on a good frame, o_frame_err on a bad stop bit.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_byte,
  output logic                 o_done,
  output logic                 o_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  uart_state_t          r_state;
  uart_state_t          w_state_next;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_rx_s;
  logic                 w_half;
  logic                 w_full;

  // Synchronizer flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;
  assign w_half = (r_clk_cnt == HALF_CNT);
  assign w_full = (r_clk_cnt == FULL_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (!w_rx_s) w_state_next = ST_START;
      ST_START: if (w_half) w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_full && (r_bit_cnt == LAST_BIT)) w_state_next = ST_STOP;
      ST_STOP:  if (w_full) w_state_next = w_rx_s ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (w_rx_s) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_done      = 1'b0;
    o_frame_err = 1'b0;
    if (!rst && (r_state == ST_STOP) && w_full) begin
      o_done      = w_rx_s;
      o_frame_err = !w_rx_s;
    end
  end

  // Bit timing: START waits half a bit, DATA and STOP then sample once per bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      unique case (r_state)
        ST_START: r_clk_cnt <= w_half ? '0 : r_clk_cnt + 1'b1;
        ST_DATA: begin
          if (w_full) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_STOP:  r_clk_cnt <= w_full ? '0 : r_clk_cnt + 1'b1;
        default: begin
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  assign o_byte = r_shift;

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver with an AXI-Stream master output: one-deep holding register,
// tlast on the delimiter byte, and an overrun pulse when a byte must be dropped.
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int                   DATA_BITS    = 8,
  parameter int                   CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter logic [DATA_BITS-1:0] LAST_CHAR    = DATA_BITS'(UART_LAST_CHAR)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] axis_data,
  output logic                 axis_valid,
  input  logic                 axis_ready,
  output logic                 axis_last,
  output logic                 frame_err,
  output logic                 overrun
);

  logic [DATA_BITS-1:0] w_byte;
  logic                 w_done;
  logic                 w_load;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_last;
  logic                 r_valid;

  uart_rx_core #(
    .DATA_BITS    (DATA_BITS),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (uart_rx),
    .o_byte      (w_byte),
    .o_done      (w_done),
    .o_frame_err (frame_err)
  );

  // A new byte may load when the register is empty or is being drained this cycle.
  assign w_load = w_done && (!r_valid || axis_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_byte;
      r_last  <= (w_byte == LAST_CHAR);
      r_valid <= 1'b1;
    end else if (axis_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign overrun    = w_done && r_valid && !axis_ready;
  assign axis_data  = r_data;
  assign axis_last  = r_last;
  assign axis_valid = r_valid;

endmodule
